// File: rtl/wb_regbank_semver.sv
// Wishbone classic 32-bit slave: read-only semantic-version word at address 0 plus
// NUM_REGS byte-writable control registers at addresses 1..NUM_REGS, one-cycle ack/err.
module wb_regbank_semver #(
  parameter int unsigned ADDR_W    = 3,
  parameter int unsigned NUM_REGS  = 4,
  parameter logic [7:0]  VER_MAJOR = 8'd1,
  parameter logic [7:0]  VER_MINOR = 8'd2,
  parameter logic [7:0]  VER_PATCH = 8'd3,
  parameter logic [31:0] RESET_VAL = 32'h0
) (
  input  logic                     clk_i,
  input  logic                     rst_n_i,
  input  logic                     wb_cyc_i,
  input  logic                     wb_stb_i,
  input  logic [ADDR_W+1:2]        wb_adr_i,
  input  logic [3:0]               wb_sel_i,
  input  logic                     wb_we_i,
  input  logic [31:0]              wb_dat_i,
  output logic                     wb_ack_o,
  output logic                     wb_err_o,
  output logic                     wb_rty_o,
  output logic                     wb_stall_o,
  output logic [31:0]              wb_dat_o,
  output logic [32*NUM_REGS-1:0]   regs_o,
  output logic [NUM_REGS-1:0]      wr_pulse_o
);

  if (NUM_REGS < 1 || NUM_REGS > (2**ADDR_W) - 1) begin : g_bad_cfg
    $error("wb_regbank_semver: NUM_REGS must be in 1..2**ADDR_W-1");
  end

  localparam logic [ADDR_W+1:2] LAST = ADDR_W'(NUM_REGS);

  logic [31:0]       regs [NUM_REGS];
  logic              rip, wip;
  logic              ack_q, err_q, rsp_rd;
  logic [ADDR_W+1:2] rd_adr, wr_adr;
  logic              wr_go;
  logic [31:0]       wr_dat;
  logic [3:0]        wr_sel;

  logic en, rd_req, wr_req, rd_ok, wr_ok, rsp_done;

  assign en       = wb_cyc_i & wb_stb_i;
  assign rd_req   = en & ~wb_we_i & ~rip;
  assign wr_req   = en & wb_we_i & ~wip;
  assign rd_ok    = (wb_adr_i <= LAST);
  assign wr_ok    = (wb_adr_i != '0) && (wb_adr_i <= LAST);
  assign rsp_done = ack_q | err_q;

  // Request captured here; its response and any register commit happen one cycle later.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      rip        <= 1'b0;
      wip        <= 1'b0;
      ack_q      <= 1'b0;
      err_q      <= 1'b0;
      rsp_rd     <= 1'b0;
      rd_adr     <= '0;
      wr_adr     <= '0;
      wr_go      <= 1'b0;
      wr_dat     <= '0;
      wr_sel     <= '0;
      wr_pulse_o <= '0;
      for (int unsigned k = 0; k < NUM_REGS; k++) regs[k] <= RESET_VAL;
    end else begin
      rip    <= rd_req | (rip & ~rsp_done);
      wip    <= wr_req | (wip & ~rsp_done);
      ack_q  <= (rd_req & rd_ok) | (wr_req & wr_ok);
      err_q  <= (rd_req & ~rd_ok) | (wr_req & ~wr_ok);
      rsp_rd <= rd_req & rd_ok;
      wr_go  <= wr_req & wr_ok;
      if (rd_req) rd_adr <= wb_adr_i;
      if (wr_req) begin
        wr_adr <= wb_adr_i;
        wr_dat <= wb_dat_i;
        wr_sel <= wb_sel_i;
      end
      wr_pulse_o <= '0;
      if (wr_go) begin
        for (int unsigned k = 0; k < NUM_REGS; k++) begin
          if (wr_adr == ADDR_W'(k + 1)) begin
            wr_pulse_o[k] <= 1'b1;
            for (int unsigned b = 0; b < 4; b++) begin
              if (wr_sel[b]) regs[k][8*b +: 8] <= wr_dat[8*b +: 8];
            end
          end
        end
      end
    end
  end

  // Read data is muxed from live registers so a commit ending the request cycle is seen.
  always_comb begin
    wb_dat_o = '0;
    if (ack_q && rsp_rd) begin
      if (rd_adr == '0) wb_dat_o = {8'h00, VER_MAJOR, VER_MINOR, VER_PATCH};
      for (int unsigned k = 0; k < NUM_REGS; k++) begin
        if (rd_adr == ADDR_W'(k + 1)) wb_dat_o = regs[k];
      end
    end
  end

  always_comb begin
    regs_o = '0;
    for (int unsigned k = 0; k < NUM_REGS; k++) regs_o[32*k +: 32] = regs[k];
  end

  assign wb_ack_o   = ack_q;
  assign wb_err_o   = err_q;
  assign wb_rty_o   = 1'b0;
  assign wb_stall_o = en & ~rsp_done;

endmodule

// File: tb/tb_wb_regbank_semver.sv
// Directed bench for wb_regbank_semver: transaction-level model checked every cycle,
// plus literal expectations at the key points of each scenario.
module tb_wb_regbank_semver;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         cyc = 1'b0, stb = 1'b0, we = 1'b0;
  logic [2:0]   adr = '0;
  logic [3:0]   sel = '0;
  logic [31:0]  wdat = '0;
  logic         ack, err, rty, stall;
  logic [31:0]  rdat;
  logic [127:0] regs;
  logic [3:0]   pulse;

  int unsigned nvec = 0, nbad = 0;

  wb_regbank_semver #(.ADDR_W(3), .NUM_REGS(4), .VER_MAJOR(8'd1), .VER_MINOR(8'd2),
                      .VER_PATCH(8'd3), .RESET_VAL(32'h0)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .wb_cyc_i(cyc), .wb_stb_i(stb), .wb_adr_i(adr),
    .wb_sel_i(sel), .wb_we_i(we), .wb_dat_i(wdat), .wb_ack_o(ack), .wb_err_o(err),
    .wb_rty_o(rty), .wb_stall_o(stall), .wb_dat_o(rdat), .regs_o(regs), .wr_pulse_o(pulse)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    nvec++;
    if (act !== exp) begin
      nbad++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Transaction model: each accepted request produces exactly one response in the next
  // cycle; a legal write lands in the register array at the end of that response cycle.
  logic [31:0] m_regs [4];
  logic        m_ack, m_err, m_rd;
  logic [31:0] m_dat;
  logic [3:0]  m_pulse;
  logic        c_v;
  logic [2:0]  c_adr;
  logic [31:0] c_dat;
  logic [3:0]  c_sel;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) m_regs[i] = 32'h0;
      m_ack = 0; m_err = 0; m_rd = 0; m_dat = 0; m_pulse = 0; c_v = 0;
    end else begin
      logic        busy_r, busy_w, n_ack, n_err, n_rd, n_cv;
      logic [31:0] n_dat;
      logic [3:0]  n_pulse;
      busy_r = (m_ack | m_err) & m_rd;
      busy_w = (m_ack | m_err) & ~m_rd;
      n_pulse = 0;
      if (c_v) begin
        for (int b = 0; b < 4; b++)
          if (c_sel[b]) m_regs[c_adr - 1][8*b +: 8] = c_dat[8*b +: 8];
        n_pulse[c_adr - 1] = 1'b1;
      end
      n_ack = 0; n_err = 0; n_rd = 0; n_cv = 0; n_dat = 0;
      if (cyc && stb && !we && !busy_r) begin
        n_rd = 1;
        if (adr <= 3'd4) begin
          n_ack = 1;
          n_dat = (adr == 0) ? 32'h0001_0203 : m_regs[adr - 1];
        end else n_err = 1;
      end
      if (cyc && stb && we && !busy_w) begin
        if (adr >= 3'd1 && adr <= 3'd4) begin
          n_ack = 1; n_cv = 1; c_adr = adr; c_dat = wdat; c_sel = sel;
        end else n_err = 1;
      end
      m_ack = n_ack; m_err = n_err; m_rd = n_rd; m_dat = n_dat; m_pulse = n_pulse; c_v = n_cv;
    end
  end

  always @(negedge clk) begin
    chk("ack", {127'b0, ack}, {127'b0, m_ack});
    chk("err", {127'b0, err}, {127'b0, m_err});
    chk("rty", {127'b0, rty}, 128'b0);
    chk("stall", {127'b0, stall}, {127'b0, cyc & stb & ~(m_ack | m_err)});
    chk("dat", {96'b0, rdat}, {96'b0, m_dat});
    chk("regs", regs, {m_regs[3], m_regs[2], m_regs[1], m_regs[0]});
    chk("pulse", {124'b0, pulse}, {124'b0, m_pulse});
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic w, input logic [2:0] a, input logic [31:0] d,
                       input logic [3:0] s);
    cyc = 1; stb = 1; we = w; adr = a; wdat = d; sel = s;
  endtask

  task automatic idle();
    cyc = 0; stb = 0; we = $urandom_range(0, 1);
    adr = 3'($urandom); wdat = $urandom; sel = 4'($urandom);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    chk("rst_ack", {127'b0, ack}, 128'b0);
    chk("rst_regs", regs, 128'b0);
    @(posedge clk); #1;
    rst_n = 1;
    step();

    // 1: version read
    drive(0, 3'd0, 32'h0, 4'h0); step(); idle();
    @(negedge clk);
    chk("t1_ack", {127'b0, ack}, 128'd1);
    chk("t1_dat", {96'b0, rdat}, 128'h0001_0203);
    chk("t1_err", {127'b0, err}, 128'b0);
    step();

    // 2: full write then read back
    drive(1, 3'd2, 32'hDEAD_BEEF, 4'b1111); step(); idle();
    @(negedge clk);
    chk("t2_ack", {127'b0, ack}, 128'd1);
    step(); @(negedge clk);
    chk("t2_reg", {96'b0, regs[63:32]}, 128'hDEAD_BEEF);
    chk("t2_pulse", {124'b0, pulse}, 128'b0010);
    step(); @(negedge clk);
    chk("t2_pulse_off", {124'b0, pulse}, 128'b0);
    drive(0, 3'd2, 32'h0, 4'h0); step(); idle();
    @(negedge clk);
    chk("t2_rd", {96'b0, rdat}, 128'hDEAD_BEEF);
    step();

    // 3: partial byte write
    drive(1, 3'd2, 32'h1122_3344, 4'b0101); step(); idle(); step();
    @(negedge clk);
    chk("t3_reg", {96'b0, regs[63:32]}, 128'hDE22_BE44);
    step();

    // 4: illegal write to version word, illegal read past last register
    drive(1, 3'd0, 32'hFFFF_FFFF, 4'b1111); step(); idle();
    @(negedge clk);
    chk("t4_werr", {126'b0, err, ack}, 128'b10);
    step(); @(negedge clk);
    chk("t4_pulse", {124'b0, pulse}, 128'b0);
    drive(0, 3'd5, 32'h0, 4'h0); step(); idle();
    @(negedge clk);
    chk("t4_rerr", {126'b0, err, ack}, 128'b10);
    chk("t4_rdat", {96'b0, rdat}, 128'b0);
    step();

    // 5: strobe held until ack -> single access
    drive(1, 3'd1, 32'hA5A5_0001, 4'b1111);
    @(negedge clk);
    chk("t5_stall_T", {127'b0, stall}, 128'd1);
    step(); @(negedge clk);
    chk("t5_ack", {127'b0, ack}, 128'd1);
    chk("t5_stall_T1", {127'b0, stall}, 128'b0);
    step(); idle(); @(negedge clk);
    chk("t5_pulse", {124'b0, pulse}, 128'b0001);
    chk("t5_noack", {127'b0, ack}, 128'b0);
    step();

    // Model-checked extras: back-to-back, write->read turnaround, sel=0, cyc drop
    drive(1, 3'd4, 32'h0BAD_F00D, 4'b1100); repeat (3) step(); idle(); repeat (2) step();
    drive(1, 3'd3, 32'h7777_8888, 4'b1111); step();
    drive(0, 3'd3, 32'h0, 4'h0); step(); idle(); repeat (2) step();
    drive(1, 3'd3, 32'hFFFF_FFFF, 4'b0000); step(); idle(); repeat (2) step();
    drive(0, 3'd4, 32'h0, 4'h0); step(); cyc = 0; repeat (2) step(); idle(); step();
    drive(0, 3'd7, 32'h0, 4'h0); step(); drive(0, 3'd1, 32'h0, 4'h0); repeat (2) step();
    idle(); repeat (2) step();

    // 6: reset during the response cycle of a write
    drive(1, 3'd3, 32'h1234_5678, 4'b1111); step(); idle();
    rst_n = 0;
    #1;
    chk("t6_ack", {127'b0, ack}, 128'b0);
    chk("t6_regs", regs, 128'b0);
    chk("t6_outs", {96'b0, rdat, err, pulse}, 128'b0);
    repeat (2) step();
    rst_n = 1;
    step();
    @(negedge clk);
    chk("t6_reg3", {96'b0, regs[127:96] | regs[95:64]}, 128'b0);
    chk("t6_pulse", {124'b0, pulse}, 128'b0);
    drive(0, 3'd3, 32'h0, 4'h0); step(); idle();
    @(negedge clk);
    chk("t6_rd3", {96'b0, rdat}, 128'h0);
    chk("t6_rdack", {127'b0, ack}, 128'd1);
    repeat (2) step();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
    $finish;
  end

endmodule
